mosby_pc_unit: RTL and testbench

//  Parametrised program-counter/branch sequencer for the mosby core; successor to the fixed
//  16-bit PC logic. Fetches the reset vector after reset and performs PC increment, absolute

---
 rtl/mosby_pkg.sv | 29 ++
 rtl/mosby_branch_cond.sv | 26 ++
 rtl/mosby_pc_unit.sv | 121 ++++++++++++
 tb/tb_mosby_pc_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mosby_pkg.sv
// Shared types and constants for the mosby program-counter/branch sequencer.
// Also used by decoder tests that reuse mosby_branch_cond.
package mosby_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2,
    FIX    = 2'd3
  } state_e;

  // Even codes branch on a clear flag, odd codes on a set flag.
  typedef enum logic [2:0] {
    BPL = 3'd0,
    BMI = 3'd1,
    BVC = 3'd2,
    BVS = 3'd3,
    BCC = 3'd4,
    BCS = 3'd5,
    BNE = 3'd6,
    BEQ = 3'd7
  } branch_op_e;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/mosby_branch_cond.sv
// Combinational branch-condition evaluator: selects one status flag by
// branch_op[2:1] and compares it with the polarity in branch_op[0].
module mosby_branch_cond
  import mosby_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic [7:0] status,
  output logic       taken
);

  logic flag;

  always_comb begin
    // NOTE: default assignment first so no path leaves flag unassigned (no latch).
    flag = status[FLAG_N];
    unique case (branch_op[2:1])
      2'd0: flag = status[FLAG_N];
      2'd1: flag = status[FLAG_V];
      2'd2: flag = status[FLAG_C];
      2'd3: flag = status[FLAG_Z];
    endcase
  end

  assign taken = (flag == branch_op[0]);

endmodule

// File: rtl/mosby_pc_unit.sv
// Program-counter/branch sequencer: reset-vector fetch, increment, absolute
// jumps from latched target bytes and 6502-style relative branches.
module mosby_pc_unit
  import mosby_pkg::*;
#(
  parameter int                 ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC    = ADDR_W'(16'hFFFC),
  parameter bit                 PAGE_PENALTY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              branch_con,
  input  logic              branch_uncon,
  input  logic              load_lo,
  input  logic              load_hi,
  input  logic [2:0]        branch_op,
  input  logic [7:0]        status,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] addr,
  output logic              vec_req,
  output logic              busy,
  output logic              branch_taken,
  output logic              page_cross
);

  localparam int PG_W = ADDR_W - 8;

  state_e            state;
  logic [7:0]        tgt_lo;
  logic [PG_W-1:0]   tgt_hi;
  logic [7:0]        vec_lo;
  logic [PG_W-1:0]   fix_pg;

  logic              cond_taken;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] br_tgt;
  logic              crosses;

  mosby_branch_cond u_cond (
    .branch_op (branch_op),
    .status    (status),
    .taken     (cond_taken)
  );

  // pc already points past the offset operand, so the offset is relative to it.
  assign pc_plus = pc + ADDR_W'(1);
  assign br_tgt  = pc + {{PG_W{data_in[7]}}, data_in};
  assign crosses = (br_tgt[ADDR_W-1:8] != pc[ADDR_W-1:8]);

  assign busy    = (state != RUN);
  assign vec_req = (state == VEC_LO) || (state == VEC_HI);

  always_comb begin
    addr = pc;
    unique case (state)
      VEC_LO:  addr = RESET_VEC;
      VEC_HI:  addr = RESET_VEC + ADDR_W'(1);
      default: addr = pc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= VEC_LO;
      pc           <= RESET_VEC;
      tgt_lo       <= '0;
      tgt_hi       <= '0;
      vec_lo       <= '0;
      fix_pg       <= '0;
      branch_taken <= 1'b0;
      page_cross   <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      page_cross   <= 1'b0;
      unique case (state)
        VEC_LO: begin
          vec_lo <= data_in;
          state  <= VEC_HI;
        end
        VEC_HI: begin
          pc    <= {PG_W'(data_in), vec_lo};
          state <= RUN;
        end
        RUN: begin
          if (load_lo) tgt_lo <= data_in;
          if (load_hi) tgt_hi <= PG_W'(data_in);
          // A jump in the same cycle as a load still sees the old target bytes.
          if (branch_uncon) begin
            pc <= {tgt_hi, tgt_lo};
          end else if (branch_con) begin
            if (cond_taken) begin
              branch_taken <= 1'b1;
              page_cross   <= crosses;
              if (crosses && PAGE_PENALTY) begin
                pc     <= {pc[ADDR_W-1:8], br_tgt[7:0]};
                fix_pg <= br_tgt[ADDR_W-1:8];
                state  <= FIX;
              end else begin
                pc <= br_tgt;
              end
            end else begin
              pc <= pc_plus;
            end
          end else if (pc_inc) begin
            pc <= pc_plus;
          end
        end
        FIX: begin
          pc    <= {fix_pg, pc[7:0]};
          state <= RUN;
        end
        default: state <= VEC_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_mosby_pc_unit.sv
// Scoreboard bench for mosby_pc_unit: a PAGE_PENALTY=1 and a PAGE_PENALTY=0
// instance share stimulus; expected outputs are queued per cycle and compared.
module tb_mosby_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_inc = 0, branch_con = 0, branch_uncon = 0, load_lo = 0, load_hi = 0;
  logic [2:0]  branch_op = '0;
  logic [7:0]  status = '0, data_in = '0;
  logic [15:0] pc, addr, pc_np, addr_np;
  logic        vec_req, busy, branch_taken, page_cross;
  logic        vec_req_np, busy_np, taken_np, cross_np;

  always #5 clk = ~clk;

  mosby_pc_unit dut (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .branch_con(branch_con),
    .branch_uncon(branch_uncon), .load_lo(load_lo), .load_hi(load_hi),
    .branch_op(branch_op), .status(status), .data_in(data_in),
    .pc(pc), .addr(addr), .vec_req(vec_req), .busy(busy),
    .branch_taken(branch_taken), .page_cross(page_cross)
  );

  mosby_pc_unit #(.PAGE_PENALTY(1'b0)) dut_np (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .branch_con(branch_con),
    .branch_uncon(branch_uncon), .load_lo(load_lo), .load_hi(load_hi),
    .branch_op(branch_op), .status(status), .data_in(data_in),
    .pc(pc_np), .addr(addr_np), .vec_req(vec_req_np), .busy(busy_np),
    .branch_taken(taken_np), .page_cross(cross_np)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] addr;
    logic        busy;
    logic        vec_req;
    logic        taken;
    logic        pcross;
    logic [15:0] pc_np;
    logic        busy_np;
  } obs_t;

  typedef struct {
    logic       uncon, con, inc, lo, hi;
    logic [2:0] op;
    logic [7:0] st, d;
    obs_t       exp;
  } row_t;

  obs_t        sb[$];
  row_t        rows[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cur = 16'h0000;
  logic [15:0] cur_np = 16'h0000;

  function automatic obs_t sample();
    return '{pc: pc, addr: addr, busy: busy, vec_req: vec_req, taken: branch_taken,
             pcross: page_cross, pc_np: pc_np, busy_np: busy_np};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pc=%h addr=%h busy=%b vreq=%b bt=%b pgx=%b pc_np=%h busy_np=%b",
                     o.pc, o.addr, o.busy, o.vec_req, o.taken, o.pcross, o.pc_np, o.busy_np);
  endfunction

  function automatic obs_t run_o(logic [15:0] p, logic tk, logic pcx, logic [15:0] p_np);
    return '{pc: p, addr: p, busy: 1'b0, vec_req: 1'b0, taken: tk, pcross: pcx,
             pc_np: p_np, busy_np: 1'b0};
  endfunction

  function automatic obs_t fix_o(logic [15:0] p, logic [15:0] p_np);
    return '{pc: p, addr: p, busy: 1'b1, vec_req: 1'b0, taken: 1'b1, pcross: 1'b1,
             pc_np: p_np, busy_np: 1'b0};
  endfunction

  function automatic obs_t rst_o(logic [15:0] a);
    return '{pc: 16'hFFFC, addr: a, busy: 1'b1, vec_req: 1'b1, taken: 1'b0, pcross: 1'b0,
             pc_np: 16'hFFFC, busy_np: 1'b1};
  endfunction

  function automatic row_t mk(logic uncon, logic con, logic inc, logic lo, logic hi,
                              logic [2:0] op, logic [7:0] st, logic [7:0] d, obs_t e);
    row_t r;
    r.uncon = uncon; r.con = con; r.inc = inc; r.lo = lo; r.hi = hi;
    r.op = op; r.st = st; r.d = d; r.exp = e;
    return r;
  endfunction

  // Three rows that load a target and jump there from the tracked pcs.
  task automatic add_jump(input logic [15:0] tgt);
    rows.push_back(mk(0, 0, 0, 1, 0, 3'd0, 8'h00, tgt[7:0],  run_o(cur, 0, 0, cur_np)));
    rows.push_back(mk(0, 0, 0, 0, 1, 3'd0, 8'h00, tgt[15:8], run_o(cur, 0, 0, cur_np)));
    rows.push_back(mk(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00,     run_o(tgt, 0, 0, tgt)));
    cur    = tgt;
    cur_np = tgt;
  endtask

  task automatic apply(input row_t r);
    branch_uncon = r.uncon; branch_con = r.con; pc_inc = r.inc;
    load_lo = r.lo; load_hi = r.hi; branch_op = r.op; status = r.st; data_in = r.d;
  endtask

  task automatic idle_inputs();
    branch_uncon = 0; branch_con = 0; pc_inc = 0; load_lo = 0; load_hi = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    int   i = 0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(rst_o(16'hFFFC));
    o = sample(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_state: got %s want %s", fmt(o), fmt(e)); end
    rst = 1'b0;
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, rst_o(16'hFFFD)));
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'hC0, run_o(16'hC000, 0, 0, 16'hC000)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL vector_fetch[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    cur = 16'hC000; cur_np = 16'hC000;
  endtask

  task automatic test_branch_same_page();
    obs_t o, e;
    int   i = 0;
    add_jump(16'hC010);
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd7, 8'h02, 8'h05, run_o(16'hC015, 1, 0, 16'hC015)));
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, run_o(16'hC015, 0, 0, 16'hC015)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL same_page[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    cur = 16'hC015; cur_np = 16'hC015;
  endtask

  task automatic test_page_cross();
    obs_t o, e;
    int   i = 0;
    add_jump(16'hC0FE);
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd7, 8'h02, 8'h10, fix_o(16'hC00E, 16'hC10E)));
    // Requests during FIX are ignored by the stalled unit; the no-penalty one is in RUN.
    rows.push_back(mk(0, 0, 1, 1, 0, 3'd0, 8'h00, 8'h77, run_o(16'hC10E, 0, 0, 16'hC10F)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL page_cross[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    cur = 16'hC10E; cur_np = 16'hC10F;
  endtask

  task automatic test_bne();
    obs_t o, e;
    int   i = 0;
    add_jump(16'hC000);
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd6, 8'h02, 8'hF0, run_o(16'hC001, 0, 0, 16'hC001)));
    cur = 16'hC001; cur_np = 16'hC001;
    add_jump(16'hC000);
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd6, 8'h00, 8'hF0, fix_o(16'hC0F0, 16'hBFF0)));
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, run_o(16'hBFF0, 0, 0, 16'hBFF0)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bne[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    cur = 16'hBFF0; cur_np = 16'hBFF0;
  endtask

  // Zero offset: a taken branch leaves pc in place, a not-taken one steps past it.
  // pc_inc is held high to show a branch request outranks it.
  task automatic test_conditions();
    obs_t        o, e;
    logic [15:0] p = cur;
    for (int op = 0; op < 8; op++) begin
      for (int s = 0; s < 2; s++) begin
        logic tk = ((s == 1) == op[0]);
        if (!tk) p = p + 16'd1;
        rows.push_back(mk(0, 1, 1, 0, 0, 3'(op), (s == 1) ? 8'hFF : 8'h00, 8'h00,
                          run_o(p, tk, 0, p)));
      end
    end
    for (int i = 0; rows.size() > 0; i++) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL cond op=%0d st=%h: got %s want %s", r.op, r.st, fmt(o), fmt(e));
      end
    end
    cur = p; cur_np = p;
  endtask

  task automatic test_priority_wrap();
    obs_t o, e;
    int   i = 0;
    rows.push_back(mk(0, 0, 0, 1, 0, 3'd0, 8'h00, 8'h34, run_o(cur, 0, 0, cur)));
    rows.push_back(mk(0, 0, 0, 0, 1, 3'd0, 8'h00, 8'h12, run_o(cur, 0, 0, cur)));
    rows.push_back(mk(1, 1, 1, 1, 0, 3'd0, 8'h00, 8'h99, run_o(16'h1234, 0, 0, 16'h1234)));
    rows.push_back(mk(1, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, run_o(16'h1299, 0, 0, 16'h1299)));
    cur = 16'h1299; cur_np = 16'h1299;
    add_jump(16'hFFFF);
    rows.push_back(mk(0, 0, 1, 0, 0, 3'd0, 8'h00, 8'h00, run_o(16'h0000, 0, 0, 16'h0000)));
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd0, 8'h00, 8'hFF, fix_o(16'h00FF, 16'hFFFF)));
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h00, run_o(16'hFFFF, 0, 0, 16'hFFFF)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL prio_wrap[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    cur = 16'hFFFF; cur_np = 16'hFFFF;
  endtask

  task automatic test_reset_in_fix();
    obs_t o, e;
    int   i = 0;
    add_jump(16'hC0FE);
    rows.push_back(mk(0, 1, 0, 0, 0, 3'd7, 8'h02, 8'h10, fix_o(16'hC00E, 16'hC10E)));
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL into_fix[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
    idle_inputs();
    #3 rst = 1'b1;
    #1;
    sb.push_back(rst_o(16'hFFFC));
    o = sample(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_mid_fix: got %s want %s", fmt(o), fmt(e)); end
    tick();
    rst = 1'b0;
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h34, rst_o(16'hFFFD)));
    rows.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, 8'h12, run_o(16'h1234, 0, 0, 16'h1234)));
    i = 0;
    while (rows.size() > 0) begin
      row_t r = rows.pop_front();
      apply(r); sb.push_back(r.exp); tick();
      o = sample(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL refetch[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_branch_same_page();
    test_page_cross();
    test_bne();
    test_conditions();
    test_priority_wrap();
    test_reset_in_fix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
